// File: rtl/pipeline_pkg.sv
// Shared RV32 pipeline types: control bundles, ALU and mul/div opcodes,
// and the iterative mul/div engine parameters.
package pipeline_pkg;

    localparam int MULDIV_ITERATIONS = 32;

    typedef logic [4:0] RegisterID_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_PASSB
    } AluOp_t;

    typedef enum logic [2:0] {
        MD_MUL,
        MD_MULH,
        MD_MULHSU,
        MD_MULHU,
        MD_DIV,
        MD_DIVU,
        MD_REM,
        MD_REMU
    } MulDivOp_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } MdState_t;

    typedef struct packed {
        AluOp_t    AluOp;
        logic      AluSrcImm;
        logic      AluSrcPC;
        logic      IsMulDiv;
        MulDivOp_t MulDivOp;
    } EX_Control_t;

    typedef struct packed {
        logic       MemRead;
        logic       MemWrite;
        logic [2:0] Funct3;
    } MEM_Control_t;

    typedef struct packed {
        logic RegWrite;
        logic MemToReg;
    } WB_Control_t;

    function automatic logic is_div_op(input MulDivOp_t op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M engine: magnitude shift-add multiply / restoring divide,
// one bit per cycle, with the sign fix-up and special cases applied in DONE.
//   state | meaning
//   IDLE  | waiting for start; operands latched on start
//   BUSY  | one iteration per cycle, count 0..31
//   DONE  | o_Result valid for this cycle only
module muldiv_unit
    import pipeline_pkg::*;
(
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Start,
    input  logic        i_Abort,
    input  MulDivOp_t   i_Op,
    input  logic [31:0] i_A,
    input  logic [31:0] i_B,
    output logic        o_Busy,
    output logic        o_Done,
    output logic [31:0] o_Result
);

    MdState_t    r_State, w_NextState;
    logic [4:0]  r_Count;
    logic [31:0] r_Hi, r_Lo, r_M;
    MulDivOp_t   r_Op;
    logic        r_NegQ, r_NegR, r_DivZero;

    logic        w_NegA, w_NegB;
    logic [31:0] w_MagA, w_MagB;
    logic [32:0] w_Sum, w_Shift;
    logic        w_Ge;
    logic [31:0] w_RemNext;
    logic [63:0] w_Prod;
    logic [31:0] w_Quot, w_Rem;

    always_comb begin
        w_NegA = i_A[31] && (i_Op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
        w_NegB = i_B[31] && (i_Op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
        w_MagA = w_NegA ? -i_A : i_A;
        w_MagB = w_NegB ? -i_B : i_B;
    end

    // r_Hi:r_Lo is the product shift register for MUL*, remainder:quotient for DIV*
    always_comb begin
        w_Sum     = {1'b0, r_Hi} + (r_Lo[0] ? {1'b0, r_M} : 33'd0);
        w_Shift   = {r_Hi, r_Lo[31]};
        w_Ge      = (w_Shift >= {1'b0, r_M});
        w_RemNext = w_Ge ? 32'(w_Shift - {1'b0, r_M}) : w_Shift[31:0];
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State <= MD_IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    always_comb begin
        w_NextState = r_State;
        case (r_State)
            MD_IDLE: if (i_Start && !i_Abort) w_NextState = MD_BUSY;
            MD_BUSY: begin
                if (i_Abort) begin
                    w_NextState = MD_IDLE;
                end else if (r_Count == 5'(MULDIV_ITERATIONS - 1)) begin
                    w_NextState = MD_DONE;
                end
            end
            MD_DONE: w_NextState = MD_IDLE;
            default: w_NextState = MD_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Count <= '0;
        end else begin
            case (r_State)
                MD_IDLE: begin
                    if (i_Start && !i_Abort) begin
                        r_Op      <= i_Op;
                        r_Count   <= '0;
                        r_Hi      <= '0;
                        r_Lo      <= is_div_op(i_Op) ? w_MagA : w_MagB;
                        r_M       <= is_div_op(i_Op) ? w_MagB : w_MagA;
                        r_NegQ    <= w_NegA ^ w_NegB;
                        r_NegR    <= w_NegA;
                        r_DivZero <= (i_B == 32'd0);
                    end
                end
                MD_BUSY: begin
                    r_Count <= r_Count + 5'd1;
                    if (is_div_op(r_Op)) begin
                        r_Hi <= w_RemNext;
                        r_Lo <= {r_Lo[30:0], w_Ge};
                    end else begin
                        r_Hi <= w_Sum[32:1];
                        r_Lo <= {w_Sum[0], r_Lo[31:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Divide overflow (-2^31 / -1) falls out of the magnitude path; only /0 needs forcing
    always_comb begin
        w_Prod   = r_NegQ ? -{r_Hi, r_Lo} : {r_Hi, r_Lo};
        w_Quot   = r_NegQ ? -r_Lo : r_Lo;
        w_Rem    = r_NegR ? -r_Hi : r_Hi;
        o_Result = '0;
        case (r_Op)
            MD_MUL:                       o_Result = w_Prod[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: o_Result = w_Prod[63:32];
            MD_DIV, MD_DIVU:              o_Result = r_DivZero ? 32'hFFFF_FFFF : w_Quot;
            MD_REM, MD_REMU:              o_Result = w_Rem;
            default:                      o_Result = '0;
        endcase
    end

    assign o_Busy = (r_State == MD_BUSY);
    assign o_Done = (r_State == MD_DONE);

endmodule

// File: rtl/stage_execute.sv
// RV32 EX stage: operand muxes, single-cycle ALU, iterative mul/div with
// upstream stall, and the EX/MEM register. STAGE_EXECUTE_FAST_MUL_EN moves MUL* to a 1-cycle multiplier.
module stage_execute
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    input  EX_Control_t     i_EX_Control,
    input  MEM_Control_t    i_MEM_Control,
    input  WB_Control_t     i_WB_Control,
    input  RegisterID_t     i_rd,
    input  logic [XLEN-1:0] i_rs1Value,
    input  logic [XLEN-1:0] i_rs2Value,
    input  logic [XLEN-1:0] i_Immediate,
    input  logic [XLEN-1:0] i_PC,
    input  logic            i_Flush,
    output logic            o_Stall,
    output MEM_Control_t    o_MEM_Control,
    output WB_Control_t     o_WB_Control,
    output RegisterID_t     o_rd,
    output logic [XLEN-1:0] o_AluOutput,
    output logic [XLEN-1:0] o_rs2Value
);

    logic [XLEN-1:0] w_OpA, w_OpB, w_AluResult, w_ExResult, w_MdResult;
    logic [4:0]      w_Shamt;
    logic            w_NeedsIter, w_MdBusy, w_MdDone, w_MdIdle, w_Start;
    MEM_Control_t    r_LatMEM;
    WB_Control_t     r_LatWB;
    RegisterID_t     r_LatRd;

    always_comb begin
        w_OpA   = i_EX_Control.AluSrcPC  ? i_PC        : i_rs1Value;
        w_OpB   = i_EX_Control.AluSrcImm ? i_Immediate : i_rs2Value;
        w_Shamt = w_OpB[4:0];
    end

    always_comb begin
        w_AluResult = '0;
        case (i_EX_Control.AluOp)
            ALU_ADD:   w_AluResult = w_OpA + w_OpB;
            ALU_SUB:   w_AluResult = w_OpA - w_OpB;
            ALU_AND:   w_AluResult = w_OpA & w_OpB;
            ALU_OR:    w_AluResult = w_OpA | w_OpB;
            ALU_XOR:   w_AluResult = w_OpA ^ w_OpB;
            ALU_SLL:   w_AluResult = w_OpA << w_Shamt;
            ALU_SRL:   w_AluResult = w_OpA >> w_Shamt;
            ALU_SRA:   w_AluResult = $signed(w_OpA) >>> w_Shamt;
            ALU_SLT:   w_AluResult = {31'd0, $signed(w_OpA) < $signed(w_OpB)};
            ALU_SLTU:  w_AluResult = {31'd0, w_OpA < w_OpB};
            ALU_PASSB: w_AluResult = w_OpB;
            default:   w_AluResult = '0;
        endcase
    end

`ifdef STAGE_EXECUTE_FAST_MUL_EN
    logic        w_MulSA, w_MulSB;
    logic [63:0] w_MulA, w_MulB, w_MulProd;

    // Operands sign- or zero-extended to 64 bits; the low 64 product bits are exact
    always_comb begin
        w_MulSA   = (i_EX_Control.MulDivOp != MD_MULHU) && i_rs1Value[31];
        w_MulSB   = (i_EX_Control.MulDivOp inside {MD_MUL, MD_MULH}) && i_rs2Value[31];
        w_MulA    = {{32{w_MulSA}}, i_rs1Value};
        w_MulB    = {{32{w_MulSB}}, i_rs2Value};
        w_MulProd = w_MulA * w_MulB;
    end

    assign w_NeedsIter = i_EX_Control.IsMulDiv && is_div_op(i_EX_Control.MulDivOp);
    assign w_ExResult  = !i_EX_Control.IsMulDiv ? w_AluResult :
                         (i_EX_Control.MulDivOp == MD_MUL) ? w_MulProd[31:0] : w_MulProd[63:32];
`else
    assign w_NeedsIter = i_EX_Control.IsMulDiv;
    assign w_ExResult  = w_AluResult;
`endif

    muldiv_unit u_muldiv (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Start  (w_NeedsIter),
        .i_Abort  (i_Flush),
        .i_Op     (i_EX_Control.MulDivOp),
        .i_A      (i_rs1Value),
        .i_B      (i_rs2Value),
        .o_Busy   (w_MdBusy),
        .o_Done   (w_MdDone),
        .o_Result (w_MdResult)
    );

    assign w_MdIdle = !w_MdBusy && !w_MdDone;
    assign w_Start  = w_MdIdle && w_NeedsIter && !i_Flush && !i_Reset;
    assign o_Stall  = !i_Reset && !i_Flush && (w_Start || w_MdBusy);

    always_ff @(posedge i_Clock) begin
        if (w_Start) begin
            r_LatMEM <= i_MEM_Control;
            r_LatWB  <= i_WB_Control;
            r_LatRd  <= i_rd;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_MEM_Control <= '0;
            o_WB_Control  <= '0;
            o_rd          <= '0;
            o_AluOutput   <= '0;
            o_rs2Value    <= '0;
        end else if (i_Flush || o_Stall) begin
            o_MEM_Control.MemRead  <= 1'b0;
            o_MEM_Control.MemWrite <= 1'b0;
            o_WB_Control.RegWrite  <= 1'b0;
        end else if (w_MdDone) begin
            o_MEM_Control <= r_LatMEM;
            o_WB_Control  <= r_LatWB;
            o_rd          <= r_LatRd;
            o_AluOutput   <= w_MdResult;
            o_rs2Value    <= i_rs2Value;
        end else begin
            o_MEM_Control <= i_MEM_Control;
            o_WB_Control  <= i_WB_Control;
            o_rd          <= i_rd;
            o_AluOutput   <= w_ExResult;
            o_rs2Value    <= i_rs2Value;
        end
    end

endmodule
